wallace_product_accumulator: RTL and testbench

- Downstream consumer of the 6-bit Wallace-tree multiplier's 17-bit `result` output.
- Accepts one product per cycle over a valid/ready handshake and sums a batch of products (dot-product / MAC style).
- Presents the registered batch total, with term count and overflow status, over a second valid/ready handshake.
- Sits between the combinational multiplier and the result sink.

---
 rtl/wallace_pkg.sv | 24 ++
 rtl/wallace_product_accumulator_if.sv | 26 ++
 rtl/wallace_acc_adder.sv | 26 ++
 rtl/wallace_product_accumulator.sv | 101 ++++++++++
 tb/tb_wallace_product_accumulator.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/wallace_pkg.sv
// Shared types and constants for the Wallace product accumulator slice.
package wallace_pkg;

  localparam int unsigned PROD_W_DEF = 17;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  // Ceiling log2 for toolflows without $clog2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wallace_product_accumulator_if.sv
// Product-in and total-out valid/ready handshakes of the accumulator.
interface wallace_product_accumulator_if #(
  parameter int unsigned PROD_W = 17,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_overflow
  );
endinterface

// File: rtl/wallace_acc_adder.sv
// Accumulator add stage: ACC_W+1-bit sum with carry-out and wrap/saturate select.
// Build option: define WALLACE_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module wallace_acc_adder #(
  parameter int unsigned PROD_W = 17,
  parameter int unsigned ACC_W  = 24
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum_c,
  output logic              carry_c
);

  logic [ACC_W:0] wide;

  // Full-width add, then pick the wrapped or clamped result.
  always_comb begin
    wide    = {1'b0, acc} + (ACC_W+1)'(product);
    carry_c = wide[ACC_W];
`ifdef WALLACE_ACC_SATURATE_EN
    sum_c   = carry_c ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum_c   = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/wallace_product_accumulator.sv
// Sums a batch of multiplier products and hands the total off over valid/ready.
// Build option: WALLACE_ACC_SATURATE_EN selects saturating accumulation (see wallace_acc_adder).
module wallace_product_accumulator
  import wallace_pkg::*;
#(
  parameter int unsigned PROD_W    = PROD_W_DEF,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  wallace_product_accumulator_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] sum_c;
  logic             carry_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic             ovf_nxt_c;
  logic             term_c;

  wallace_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc     (acc),
    .product (bus.in_product),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // Next count/overflow and batch-termination decode for an accept this cycle.
  always_comb begin
    count_nxt_c = count + CNT_W'(1);
    ovf_nxt_c   = ovf | carry_c;
    term_c      = bus.in_last || (count_nxt_c == CNT_W'(MAX_TERMS));
  end

  // Batch FSM with registered handshake flags and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ACCUM;
      acc              <= '0;
      count            <= '0;
      ovf              <= 1'b0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.out_acc      <= '0;
      bus.out_count    <= '0;
      bus.out_overflow <= 1'b0;
    end else if (clear) begin
      state         <= ACCUM;
      acc           <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc   <= sum_c;
            count <= count_nxt_c;
            ovf   <= ovf_nxt_c;
            if (term_c) begin
              state            <= DONE;
              bus.in_ready     <= 1'b0;
              bus.out_valid    <= 1'b1;
              bus.out_acc      <= sum_c;
              bus.out_count    <= count_nxt_c;
              bus.out_overflow <= ovf_nxt_c;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= ACCUM;
            acc           <= '0;
            count         <= '0;
            ovf           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
          end
        end
        default: begin
          state         <= ACCUM;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Directed bench for wallace_product_accumulator (default and 17-bit accumulator instances).
module tb_wallace_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic clear17;

  always #5 clk = ~clk;

  wallace_product_accumulator_if #(.PROD_W(17), .ACC_W(24), .CNT_W(5)) bus ();
  wallace_product_accumulator_if #(.PROD_W(17), .ACC_W(17), .CNT_W(5)) bus17 ();

  wallace_product_accumulator #(.PROD_W(17), .ACC_W(24), .MAX_TERMS(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  wallace_product_accumulator #(.PROD_W(17), .ACC_W(17), .MAX_TERMS(16)) dut17 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear17),
    .bus   (bus17)
  );

  typedef struct {
    logic        valid;
    logic [16:0] prod;
    logic        last;
    logic        clr;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [23:0] e_acc;
    logic [4:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vec [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [16:0] p, input logic l, input logic c, input logic r);
    bus.in_valid   = v;
    bus.in_product = p;
    bus.in_last    = l;
    clear          = c;
    bus.out_ready  = r;
  endtask

  task automatic chk_main(input string tag, input logic rdy, input logic ov,
                          input logic [23:0] a, input logic [4:0] c, input logic o);
    chk({tag, ".in_ready"},     32'(bus.in_ready),     32'(rdy));
    chk({tag, ".out_valid"},    32'(bus.out_valid),    32'(ov));
    chk({tag, ".out_acc"},      32'(bus.out_acc),      32'(a));
    chk({tag, ".out_count"},    32'(bus.out_count),    32'(c));
    chk({tag, ".out_overflow"}, 32'(bus.out_overflow), 32'(o));
  endtask

  initial begin
    logic [16:0] exp17;

    // basic batch
    vec[0]  = '{1'b1, 17'd1242, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0,    5'd0, 1'b0};
    vec[1]  = '{1'b1, 17'd270,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'd1512, 5'd2, 1'b0};
    vec[2]  = '{1'b0, 17'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd1512, 5'd2, 1'b0};
    // backpressure
    vec[3]  = '{1'b1, 17'd1242, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'd1512, 5'd2, 1'b0};
    vec[4]  = '{1'b1, 17'd270,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'd1512, 5'd2, 1'b0};
    for (int i = 5; i < 10; i++)
      vec[i] = '{1'b1, 17'd999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'd1512, 5'd2, 1'b0};
    vec[10] = '{1'b1, 17'd999,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd1512, 5'd2, 1'b0};
    vec[11] = '{1'b1, 17'd7,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'd7,    5'd1, 1'b0};
    vec[12] = '{1'b0, 17'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd7,    5'd1, 1'b0};
    // clear in ACCUM drops the concurrent product
    vec[13] = '{1'b1, 17'd100,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd7,    5'd1, 1'b0};
    vec[14] = '{1'b1, 17'd200,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd7,    5'd1, 1'b0};
    vec[15] = '{1'b1, 17'd300,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'd7,    5'd1, 1'b0};
    vec[16] = '{1'b1, 17'd5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'd5,    5'd1, 1'b0};
    vec[17] = '{1'b0, 17'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd5,    5'd1, 1'b0};
    // clear in DONE
    vec[18] = '{1'b1, 17'd9,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'd9,    5'd1, 1'b0};
    vec[19] = '{1'b0, 17'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'd9,    5'd1, 1'b0};
    // zero product is a term
    vec[20] = '{1'b1, 17'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'd0,    5'd1, 1'b0};
    vec[21] = '{1'b0, 17'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0,    5'd1, 1'b0};
    // in_last without in_valid is ignored
    vec[22] = '{1'b0, 17'd0,    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0,    5'd1, 1'b0};
    vec[23] = '{1'b1, 17'd4,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'd4,    5'd1, 1'b0};
    vec[24] = '{1'b0, 17'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd4,    5'd1, 1'b0};

    drive(1'b0, 17'd0, 1'b0, 1'b0, 1'b0);
    clear17          = 1'b0;
    bus17.in_valid   = 1'b0;
    bus17.in_product = '0;
    bus17.in_last    = 1'b0;
    bus17.out_ready  = 1'b0;
    rst = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
    chk_main("reset", 1'b1, 1'b0, 24'd0, 5'd0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].valid, vec[i].prod, vec[i].last, vec[i].clr, vec[i].ordy);
      step();
      chk_main($sformatf("vec%0d", i), vec[i].e_rdy, vec[i].e_ov, vec[i].e_acc, vec[i].e_cnt, vec[i].e_ovf);
    end

    // forced termination after MAX_TERMS products
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 17'd3969, 1'b0, 1'b0, 1'b0);
      step();
      if (i < 15) chk($sformatf("force%0d.out_valid", i), 32'(bus.out_valid), 32'd0);
    end
    drive(1'b0, 17'd0, 1'b0, 1'b0, 1'b0);
    chk_main("force_done", 1'b0, 1'b1, 24'd63504, 5'd16, 1'b0);
    bus.out_ready = 1'b1;
    step();
    chk_main("force_handoff", 1'b1, 1'b0, 24'd63504, 5'd16, 1'b0);

    // reset while DONE loses the result
    drive(1'b1, 17'd1242, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 17'd270, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 17'd0, 1'b0, 1'b0, 1'b0);
    chk_main("rst_pre", 1'b0, 1'b1, 24'd1512, 5'd2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_main("rst_done", 1'b1, 1'b0, 24'd0, 5'd0, 1'b0);

    // overflow on 17-bit accumulator
`ifdef WALLACE_ACC_SATURATE_EN
    exp17 = 17'd131071;
`else
    exp17 = 17'd0;
`endif
    bus17.in_valid   = 1'b1;
    bus17.in_product = 17'd131071;
    step();
    bus17.in_product = 17'd1;
    bus17.in_last    = 1'b1;
    step();
    bus17.in_valid   = 1'b0;
    bus17.in_last    = 1'b0;
    chk("ovf.out_valid",    32'(bus17.out_valid),    32'd1);
    chk("ovf.out_acc",      32'(bus17.out_acc),      32'(exp17));
    chk("ovf.out_count",    32'(bus17.out_count),    32'd2);
    chk("ovf.out_overflow", 32'(bus17.out_overflow), 32'd1);
    bus17.out_ready = 1'b1;
    step();
    bus17.out_ready  = 1'b0;
    bus17.in_valid   = 1'b1;
    bus17.in_product = 17'd3;
    bus17.in_last    = 1'b1;
    step();
    bus17.in_valid = 1'b0;
    bus17.in_last  = 1'b0;
    chk("ovf2.out_acc",      32'(bus17.out_acc),      32'd3);
    chk("ovf2.out_overflow", 32'(bus17.out_overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
